// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_display
// Purpose  : Multiplexed seven-segment driver showing a value as hex, unsigned
//            or signed decimal, with leading-zero blanking and overflow dashes.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_display #(
    parameter int NUM_DIGITS     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int REFRESH_DIV    = 20000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] number,
    input  logic [1:0]            mode,
    input  logic                  blank_zeros,
    output logic [6:0]            seg7,
    output logic [NUM_DIGITS-1:0] select,
    output logic                  conv_done,
    output logic                  overflow
);

    localparam int c_BCD_DIGITS = (DATA_WIDTH * 302) / 1000 + 1;
    localparam int c_BCD_W      = 4 * c_BCD_DIGITS;
    localparam int c_BCD_PAD_W  = 4 * ((NUM_DIGITS > c_BCD_DIGITS) ? NUM_DIGITS : c_BCD_DIGITS);
    localparam int c_HEX_NIBS   = (DATA_WIDTH + 3) / 4;
    localparam int c_HEX_PAD_W  = 4 * ((NUM_DIGITS > c_HEX_NIBS) ? NUM_DIGITS : c_HEX_NIBS);
    localparam int c_BIT_W      = $clog2(DATA_WIDTH + 1);
    localparam int c_REF_W      = $clog2(REFRESH_DIV + 1);
    localparam int c_IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [c_BIT_W-1:0]    c_BIT_LAST = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_REF_W-1:0]    c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            c_SEG_DASH = 7'b1000000;
    localparam logic [6:0]            c_SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] c_SEL_OFF  = SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [DATA_WIDTH-1:0]           r_raw;
    logic [DATA_WIDTH-1:0]           r_shift;
    logic [1:0]                      r_mode;
    logic                            r_blank;
    logic                            r_neg;
    logic [c_BCD_W-1:0]              r_bcd;
    logic [c_BIT_W-1:0]              r_bit_cnt;
    logic [NUM_DIGITS-1:0][6:0]      r_disp;
    logic                            r_overflow;
    logic                            r_conv_done;
    logic [c_REF_W-1:0]              r_refresh;
    logic [c_IDX_W-1:0]              r_idx;
    logic [6:0]                      r_seg7;
    logic [NUM_DIGITS-1:0]           r_sel;

    logic                            w_neg;
    logic [DATA_WIDTH-1:0]           w_mag;
    logic [c_BCD_W-1:0]              w_bcd_adj;
    logic [c_BCD_PAD_W-1:0]          w_bcd_pad;
    logic [c_HEX_PAD_W-1:0]          w_hex_pad;
    logic [NUM_DIGITS-1:0][6:0]      w_disp_next;
    logic                            w_ovf;
    logic                            w_dec;
    logic                            w_seen;
    logic [3:0]                      w_nib;
    logic [NUM_DIGITS-1:0]           w_sel_onehot;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    // Signed mode converts the magnitude; -2^(W-1) negates to itself, which is
    // the correct magnitude when read as unsigned.
    always_comb begin
        w_neg = (mode == 2'b10) && number[DATA_WIDTH-1];
        w_mag = w_neg ? (~number + DATA_WIDTH'(1)) : number;
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < c_BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = S_CONV;
            S_CONV:   if (r_bit_cnt == c_BIT_LAST) w_state_next = S_COMMIT;
            S_COMMIT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Digit codes are built top-down so the blanking flag sees higher digits first.
    always_comb begin
        w_bcd_pad                = '0;
        w_bcd_pad[c_BCD_W-1:0]   = r_bcd;
        w_hex_pad                = '0;
        w_hex_pad[DATA_WIDTH-1:0] = r_raw;
        w_dec                    = (r_mode == 2'b01) || (r_mode == 2'b10);
        w_seen                   = 1'b0;
        w_nib                    = 4'd0;
        w_disp_next              = '0;
        case (r_mode)
            2'b01:   w_ovf = |(w_bcd_pad >> (4 * NUM_DIGITS));
            2'b10:   w_ovf = |(w_bcd_pad >> (4 * (NUM_DIGITS - 1)));
            default: w_ovf = |(w_hex_pad >> (4 * NUM_DIGITS));
        endcase
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!w_dec) begin
                w_disp_next[i] = hex_to_seg(w_hex_pad[4*i +: 4]);
            end else if ((r_mode == 2'b10) && (i == NUM_DIGITS - 1)) begin
                w_disp_next[i] = r_neg ? c_SEG_DASH : 7'h00;
            end else begin
                w_nib = w_bcd_pad[4*i +: 4];
                if (w_nib != 4'd0) w_seen = 1'b1;
                if (r_blank && !w_seen && (i != 0)) begin
                    w_disp_next[i] = 7'h00;
                end else begin
                    w_disp_next[i] = hex_to_seg(w_nib);
                end
            end
        end
        if (w_ovf) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                w_disp_next[i] = c_SEG_DASH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_raw       <= '0;
            r_shift     <= '0;
            r_mode      <= 2'b00;
            r_blank     <= 1'b0;
            r_neg       <= 1'b0;
            r_bcd       <= '0;
            r_bit_cnt   <= '0;
            r_disp      <= '0;
            r_overflow  <= 1'b0;
            r_conv_done <= 1'b0;
        end else begin
            r_conv_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_raw     <= number;
                    r_shift   <= w_mag;
                    r_mode    <= mode;
                    r_blank   <= blank_zeros;
                    r_neg     <= w_neg;
                    r_bcd     <= '0;
                    r_bit_cnt <= '0;
                end
                S_CONV: begin
                    r_bcd     <= (w_bcd_adj << 1) | c_BCD_W'(r_shift[DATA_WIDTH-1]);
                    r_shift   <= r_shift << 1;
                    r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                end
                S_COMMIT: begin
                    r_disp      <= w_disp_next;
                    r_overflow  <= w_ovf;
                    r_conv_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_sel_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;
    end

    // seg7 and select come from the same registered index, so a commit can
    // never pair one digit's enable with another digit's pattern.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_seg7    <= c_SEG_OFF;
            r_sel     <= c_SEL_OFF;
        end else begin
            if (r_refresh == c_REF_LAST) begin
                r_refresh <= '0;
                r_idx     <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
            end else begin
                r_refresh <= r_refresh + c_REF_W'(1);
            end
            r_seg7 <= SEG_ACTIVE_LOW ? ~r_disp[r_idx] : r_disp[r_idx];
            r_sel  <= SEL_ACTIVE_LOW ? ~w_sel_onehot : w_sel_onehot;
        end
    end

    assign seg7      = r_seg7;
    assign select    = r_sel;
    assign conv_done = r_conv_done;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seg7_scan_display
// Purpose  : Self-checking bench; four-digit and two-digit instances compared
//            against an arithmetic model of the displayed digits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] num_a = 8'h00, num_b = 8'h00;
    logic [1:0] mode_a = 2'b00, mode_b = 2'b00;
    logic       blk_a = 1'b0, blk_b = 1'b0;
    logic [6:0] seg7_a, seg7_b;
    logic [3:0] sel_a;
    logic [1:0] sel_b;
    logic       done_a, done_b, ovf_a, ovf_b;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seg7_scan_display #(
        .NUM_DIGITS(4), .DATA_WIDTH(8), .REFRESH_DIV(4),
        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .number(num_a), .mode(mode_a), .blank_zeros(blk_a),
        .seg7(seg7_a), .select(sel_a), .conv_done(done_a), .overflow(ovf_a)
    );

    seg7_scan_display #(
        .NUM_DIGITS(2), .DATA_WIDTH(8), .REFRESH_DIV(3),
        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .number(num_b), .mode(mode_b), .blank_zeros(blk_b),
        .seg7(seg7_b), .select(sel_b), .conv_done(done_b), .overflow(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected active-high digit patterns derived directly from the value.
    function automatic logic [55:0] model(input logic [7:0] num, input logic [1:0] md,
                                          input bit blk, input int nd, output bit ovf);
        logic [55:0] p;
        int val, mag, nm, pw;
        bit neg;
        p   = '0;
        val = int'(num);
        if (md == 2'd1 || md == 2'd2) begin
            neg = (md == 2'd2) && (val >= 128);
            mag = neg ? 256 - val : val;
            nm  = (md == 2'd2) ? nd - 1 : nd;
            pw  = 1;
            for (int i = 0; i < nm; i++) begin
                if (blk && i > 0 && mag < pw) p[7*i +: 7] = 7'h00;
                else                          p[7*i +: 7] = seg_tab[(mag / pw) % 10];
                pw = pw * 10;
            end
            ovf = (mag >= pw);
            if (md == 2'd2) p[7*(nd-1) +: 7] = neg ? 7'h40 : 7'h00;
        end else begin
            ovf = (val >> (4 * nd)) != 0;
            for (int i = 0; i < nd; i++) p[7*i +: 7] = seg_tab[(val >> (4 * i)) & 15];
        end
        if (ovf) begin
            for (int i = 0; i < nd; i++) p[7*i +: 7] = 7'h40;
        end
        return p;
    endfunction

    task automatic wait_done(input int which);
        bit got;
        got = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if ((which != 0) ? done_b : done_a) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("conv_done_wait[u%0d]", which), {31'd0, got}, 32'd1);
    endtask

    task automatic scan_check(input int which, input logic [7:0] num, input logic [1:0] md, input bit blk);
        logic [55:0] exp_p;
        bit          exp_ovf;
        logic [6:0]  got [8];
        logic [7:0]  act;
        bit          oh_ok;
        int          nd, rd;
        nd    = (which != 0) ? 2 : 4;
        rd    = (which != 0) ? 3 : 4;
        exp_p = model(num, md, blk, nd, exp_ovf);
        oh_ok = 1'b1;
        for (int d = 0; d < 8; d++) got[d] = 'x;
        check($sformatf("overflow[u%0d n=%h m=%0d]", which, num, md),
              {31'd0, (which != 0) ? ovf_b : ovf_a}, {31'd0, exp_ovf});
        @(posedge clk);
        for (int c = 0; c < nd * rd; c++) begin
            @(negedge clk);
            act = (which != 0) ? {6'h00, ~sel_b} : {4'h0, ~sel_a};
            if (!$onehot(act)) oh_ok = 1'b0;
            for (int d = 0; d < nd; d++) begin
                if (act[d]) got[d] = (which != 0) ? seg7_b : seg7_a;
            end
        end
        check($sformatf("select_onehot[u%0d]", which), {31'd0, oh_ok}, 32'd1);
        for (int d = 0; d < nd; d++) begin
            check($sformatf("digit%0d[u%0d n=%h m=%0d b=%0d]", d, which, num, md, blk),
                  {25'd0, got[d]}, {25'd0, ~exp_p[7*d +: 7]});
        end
    endtask

    task automatic apply(input int which, input logic [7:0] num, input logic [1:0] md, input bit blk);
        @(negedge clk);
        if (which != 0) begin
            num_b = num; mode_b = md; blk_b = blk;
        end else begin
            num_a = num; mode_a = md; blk_a = blk;
        end
        wait_done(which);
        wait_done(which);
        scan_check(which, num, md, blk);
    endtask

    initial begin
        int k;
        num_a = 8'hA5; mode_a = 2'b00; blk_a = 1'b0;
        num_b = 8'd150; mode_b = 2'b01; blk_b = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_seg7_a", {25'd0, seg7_a}, {25'd0, 7'h7F});
        check("reset_sel_a", {28'd0, sel_a}, {28'd0, 4'hF});
        check("reset_done_a", {31'd0, done_a}, 32'd0);
        check("reset_ovf_a", {31'd0, ovf_a}, 32'd0);
        check("reset_sel_b", {30'd0, sel_b}, {30'd0, 2'b11});

        // Release: scan order and first conv_done latency
        @(negedge clk);
        rst_n = 1'b1;
        for (k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k <= 10) begin
                check($sformatf("scan_sel_edge%0d", k), {28'd0, sel_a},
                      {28'd0, ~(4'b0001 << (((k - 1) / 4) % 4))});
                check($sformatf("blank_seg_edge%0d", k), {25'd0, seg7_a}, {25'd0, 7'h7F});
            end
            if (done_a) break;
        end
        check("first_conv_done_edge", k, 10);
        scan_check(0, 8'hA5, 2'b00, 1'b0);

        // Directed decimal cases
        apply(0, 8'd200, 2'b01, 1'b1);
        apply(0, 8'd200, 2'b01, 1'b0);
        apply(0, 8'h80, 2'b10, 1'b0);
        apply(0, 8'hFF, 2'b10, 1'b1);
        apply(0, 8'd0, 2'b01, 1'b1);
        apply(0, 8'h7F, 2'b10, 1'b1);
        apply(0, 8'h3C, 2'b11, 1'b1);

        // Two-digit overflow and recovery
        apply(1, 8'd150, 2'b01, 1'b0);
        apply(1, 8'd42, 2'b01, 1'b0);
        apply(1, 8'hF6, 2'b10, 1'b1);
        apply(1, 8'hF5, 2'b10, 1'b1);

        // Randomized
        for (int r = 0; r < 24; r++) begin
            apply(0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        for (int r = 0; r < 12; r++) begin
            apply(1, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a conversion
        apply(1, 8'd150, 2'b01, 1'b0);
        wait_done(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_seg7_a", {25'd0, seg7_a}, {25'd0, 7'h7F});
        check("midreset_sel_a", {28'd0, sel_a}, {28'd0, 4'hF});
        check("midreset_done_a", {31'd0, done_a}, 32'd0);
        check("midreset_ovf_b", {31'd0, ovf_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("postreset_blank_b", {25'd0, seg7_b}, {25'd0, 7'h7F});
            if (done_a) break;
        end
        check("postreset_conv_done_edge", k, 10);
        scan_check(0, num_a, mode_a, blk_a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
